rtc_epoch_core: RTL

Parametrised epoch timekeeping core for the z_1 RTC. It generalises the fixed 64-bit epoch timer to a configurable width and adds:
- `NUM_ALARMS` compare channels with pending/enable interrupt logic;
- an external timestamp-capture input;
- atomic multi-byte snapshot/commit access through a byte-wide register port that the SPI command FSM drives.

It sits between the divider (`tick`), the epoch trigger (`count_enable`) and the SPI FSM.

---
 rtl/rtc_epoch_core.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rtc_epoch_core.sv
// Parametrised epoch counter with alarm compares, timestamp capture and a byte-wide
// register port offering atomic snapshot reads and staged commit writes.
module rtc_epoch_core #(
   parameter int WIDTH      = 64,
   parameter int NUM_ALARMS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  count_enable,
   input  logic                  capture,
   input  logic [7:0]            addr,
   input  logic                  we,
   input  logic [7:0]            wdata,
   input  logic                  re,
   output logic [7:0]            rdata,
   output logic [NUM_ALARMS-1:0] alarm_match,
   output logic                  irq
);

   localparam int         WB        = WIDTH / 8;
   localparam logic [7:0] A_CTRL    = 8'h00;
   localparam logic [7:0] A_STATUS  = 8'h01;
   localparam logic [7:0] A_IEN     = 8'h02;
   localparam logic [7:0] A_CNT     = 8'h10;
   localparam logic [7:0] A_CAP     = 8'h20;
   localparam logic [7:0] A_ALM     = 8'h40;
   localparam logic [7:0] A_CNT_TOP = 8'(A_CNT + WB - 1);

   logic [2:0]            ctrl;          // {cap_ie, cap_en, run}
   logic [NUM_ALARMS-1:0] ien;
   logic [NUM_ALARMS-1:0] pending;
   logic                  cap_ovf;
   logic                  cap_valid;
   logic [WIDTH-1:0]      counter;
   logic [WIDTH-1:0]      shadow;
   logic [WIDTH-1:0]      cap_reg;
   logic [WIDTH-9:0]      stage_cnt;     // top byte is never staged: its write commits
   logic [WIDTH-1:0]      compare   [NUM_ALARMS];
   logic [WIDTH-9:0]      stage_cmp [NUM_ALARMS];
   logic                  cap_sync1, cap_sync2, cap_sync3, cap_edge;

   logic                  tick_ok, cnt_commit, status_wr, cap_take, cap_over;
   logic [WIDTH-1:0]      cnt_inc;
   logic [NUM_ALARMS-1:0] match, cmp_commit, pending_nxt;
   logic [7:0]            rd_byte, status_byte, ien_byte;

   assign tick_ok    = tick & count_enable & ctrl[0];
   assign cnt_commit = we && (addr == A_CNT_TOP);
   assign cnt_inc    = counter + WIDTH'(1);
   assign status_wr  = we && (addr == A_STATUS);
   assign cap_take   = cap_edge & ~cap_valid & ctrl[1];
   assign cap_over   = cap_edge & cap_valid;
   assign irq        = (|(pending & ien)) | (cap_valid & ctrl[2]);

   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      match      = '0;
      cmp_commit = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         match[k]      = tick_ok && !cnt_commit && (cnt_inc == compare[k]);
         cmp_commit[k] = we && (addr == 8'(A_ALM + 16 * k + WB - 1));
      end
      // W1C clear is applied first so a same-cycle set survives.
      pending_nxt = pending;
      if (status_wr) pending_nxt = pending_nxt & ~wdata[NUM_ALARMS-1:0];
      pending_nxt = pending_nxt | match;
   end

   always_comb begin
      status_byte                 = '0;
      status_byte[NUM_ALARMS-1:0] = pending;
      status_byte[6]              = cap_ovf;
      status_byte[7]              = cap_valid;
      ien_byte                    = '0;
      ien_byte[NUM_ALARMS-1:0]    = ien;
      rd_byte                     = '0;
      if (addr == A_CTRL)   rd_byte = {5'b0, ctrl};
      if (addr == A_STATUS) rd_byte = status_byte;
      if (addr == A_IEN)    rd_byte = ien_byte;
      for (int i = 0; i < WB; i++) begin
         // Byte 0 is live; the upper bytes come from the snapshot taken by the byte-0 read.
         if (addr == 8'(A_CNT + i)) rd_byte = (i == 0) ? counter[7:0] : shadow[8*i +: 8];
         if (addr == 8'(A_CAP + i)) rd_byte = cap_reg[8*i +: 8];
         for (int k = 0; k < NUM_ALARMS; k++)
            if (addr == 8'(A_ALM + 16 * k + i)) rd_byte = compare[k][8*i +: 8];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_sync1 <= 1'b0;
         cap_sync2 <= 1'b0;
         cap_sync3 <= 1'b0;
         cap_edge  <= 1'b0;
      end else begin
         cap_sync1 <= capture;
         cap_sync2 <= cap_sync1;
         cap_sync3 <= cap_sync2;
         cap_edge  <= cap_sync2 & ~cap_sync3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl        <= 3'b001;
         ien         <= '0;
         pending     <= '0;
         cap_ovf     <= 1'b0;
         cap_valid   <= 1'b0;
         counter     <= '0;
         shadow      <= '0;
         cap_reg     <= '0;
         stage_cnt   <= '0;
         rdata       <= '0;
         alarm_match <= '0;
         // NOTE: the compare/staging arrays are small register files that must reset, so they stay in flops.
         for (int k = 0; k < NUM_ALARMS; k++) begin
            compare[k]   <= '0;
            stage_cmp[k] <= '0;
         end
      end else begin
         alarm_match <= match;
         pending     <= pending_nxt;
         cap_ovf     <= (cap_ovf & ~(status_wr & wdata[6])) | cap_over;
         cap_valid   <= (cap_valid & ~(status_wr & wdata[7])) | cap_take;
         if (cap_take) cap_reg <= counter;

         if (re) begin
            rdata <= rd_byte;
            if (addr == A_CNT) shadow <= counter;
         end

         if (we) begin
            if (addr == A_CTRL) ctrl <= wdata[2:0];
            if (addr == A_IEN)  ien  <= wdata[NUM_ALARMS-1:0];
            for (int i = 0; i < WB - 1; i++) begin
               if (addr == 8'(A_CNT + i)) stage_cnt[8*i +: 8] <= wdata;
               for (int k = 0; k < NUM_ALARMS; k++)
                  if (addr == 8'(A_ALM + 16 * k + i)) stage_cmp[k][8*i +: 8] <= wdata;
            end
         end

         // A commit outranks an increment; the coincident tick is dropped.
         if (cnt_commit)   counter <= {wdata, stage_cnt};
         else if (tick_ok) counter <= cnt_inc;

         for (int k = 0; k < NUM_ALARMS; k++)
            if (cmp_commit[k]) compare[k] <= {wdata, stage_cmp[k]};
      end
   end

endmodule
